// File: rtl/rv_pkg.sv
// Shared RV32I pipeline encodings used by the memory and writeback stages.
package rv_pkg;

  typedef enum logic [1:0] {
    WB_MEM = 2'b00,
    WB_ALU = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_t;

  typedef enum logic [1:0] {
    SEC_BYTE = 2'b00,
    SEC_HALF = 2'b01,
    SEC_WORD = 2'b10
  } data_sec_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/regfile.sv
// Integer register file: one synchronous write port, two combinational read
// ports with write-through bypass, x0 hardwired to zero.
module regfile
  import rv_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we_i && (waddr_i != REG_X0)) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Bypass lets decode see a value in the same cycle it is being written.
  always_comb begin
    rs1_data_o = mem_q[rs1_addr_i];
    if (rs1_addr_i == REG_X0) begin
      rs1_data_o = '0;
    end else if (we_i && (rs1_addr_i == waddr_i)) begin
      rs1_data_o = wdata_i;
    end
  end

  always_comb begin
    rs2_data_o = mem_q[rs2_addr_i];
    if (rs2_addr_i == REG_X0) begin
      rs2_data_o = '0;
    end else if (we_i && (rs2_addr_i == waddr_i)) begin
      rs2_data_o = wdata_i;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: aligns control with the memory stage outputs, formats
// loads, selects the writeback source and drives the register file.
module wb_stage
  import rv_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            regWEn_i,
  input  logic [4:0]      rd_i,
  input  logic [1:0]      wbSel_i,
  input  logic [1:0]      dataSec_i,
  input  logic            ldUnsigned_i,
  input  logic [XLEN-1:0] pc4_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic [XLEN-1:0] alu_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o
);

  logic            valid_q, valid_d;
  logic [4:0]      rd_q, rd_d;
  logic [1:0]      wb_sel_q, wb_sel_d;
  logic [1:0]      data_sec_q, data_sec_d;
  logic            ld_unsigned_q, ld_unsigned_d;
  logic [XLEN-1:0] pc4_q, pc4_d;

  logic            ext;
  logic [XLEN-1:0] load_data;

  always_comb begin
    valid_d       = regWEn_i & ~flush_i;
    rd_d          = rd_i;
    wb_sel_d      = wbSel_i;
    data_sec_d    = dataSec_i;
    ld_unsigned_d = ldUnsigned_i;
    pc4_d         = pc4_i;
  end

  // Reset values select ALU/word so the stage is inert while memory resets.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= 1'b0;
      rd_q          <= REG_X0;
      wb_sel_q      <= WB_ALU;
      data_sec_q    <= SEC_WORD;
      ld_unsigned_q <= 1'b0;
      pc4_q         <= '0;
    end else begin
      valid_q       <= valid_d;
      rd_q          <= rd_d;
      wb_sel_q      <= wb_sel_d;
      data_sec_q    <= data_sec_d;
      ld_unsigned_q <= ld_unsigned_d;
      pc4_q         <= pc4_d;
    end
  end

  always_comb begin
    ext       = 1'b0;
    load_data = mem_data_i;
    case (data_sec_q)
      SEC_BYTE: begin
        ext       = ~ld_unsigned_q & mem_data_i[7];
        load_data = {{(XLEN-8){ext}}, mem_data_i[7:0]};
      end
      SEC_HALF: begin
        ext       = ~ld_unsigned_q & mem_data_i[15];
        load_data = {{(XLEN-16){ext}}, mem_data_i[15:0]};
      end
      default: load_data = mem_data_i;
    endcase
  end

  always_comb begin
    case (wb_sel_q)
      WB_MEM:  wb_data_o = load_data;
      WB_PC4:  wb_data_o = pc4_q;
      default: wb_data_o = alu_i;
    endcase
  end

  assign wb_valid_o = valid_q & (rd_q != REG_X0);
  assign wb_rd_o    = rd_q;

  regfile #(
    .NREG (NREG),
    .XLEN (XLEN)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .we_i       (wb_valid_o),
    .waddr_i    (wb_rd_o),
    .wdata_i    (wb_data_o),
    .rs1_addr_i (rs1_addr_i),
    .rs2_addr_i (rs2_addr_i),
    .rs1_data_o (rs1_data_o),
    .rs2_data_o (rs2_data_o)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: table of single-instruction vectors plus
// hand-written reset, bypass and reset-during-write sequences.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        regWEn_i;
  logic [4:0]  rd_i;
  logic [1:0]  wbSel_i;
  logic [1:0]  dataSec_i;
  logic        ldUnsigned_i;
  logic [31:0] pc4_i;
  logic [31:0] mem_data_i;
  logic [31:0] alu_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;

  always #5 clk = ~clk;

  wb_stage #(
    .NREG (32),
    .XLEN (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .regWEn_i     (regWEn_i),
    .rd_i         (rd_i),
    .wbSel_i      (wbSel_i),
    .dataSec_i    (dataSec_i),
    .ldUnsigned_i (ldUnsigned_i),
    .pc4_i        (pc4_i),
    .mem_data_i   (mem_data_i),
    .alu_i        (alu_i),
    .rs1_addr_i   (rs1_addr_i),
    .rs2_addr_i   (rs2_addr_i),
    .rs1_data_o   (rs1_data_o),
    .rs2_data_o   (rs2_data_o),
    .wb_valid_o   (wb_valid_o),
    .wb_rd_o      (wb_rd_o),
    .wb_data_o    (wb_data_o)
  );

  typedef struct {
    logic        wen;
    logic        flush;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [1:0]  sec;
    logic        uns;
    logic [31:0] pc4;
    logic [31:0] mem;
    logic [31:0] alu;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NVEC = 11;
  vec_t        vecs [NVEC];
  logic [31:0] model [32];
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic idle_ctrl();
    regWEn_i     = 1'b0;
    flush_i      = 1'b0;
    rd_i         = 5'd0;
    wbSel_i      = 2'b01;
    dataSec_i    = 2'b10;
    ldUnsigned_i = 1'b0;
    pc4_i        = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // wen flush rd sel sec uns pc4 mem alu exp_valid exp_data
    vecs[0]  = '{1, 0, 5'd5,  2'b00, 2'b00, 0, 32'h0,   32'h0000_0080, 32'h1111_1111, 1, 32'hFFFF_FF80};
    vecs[1]  = '{1, 0, 5'd6,  2'b00, 2'b01, 1, 32'h0,   32'h0000_F00D, 32'h2222_2222, 1, 32'h0000_F00D};
    vecs[2]  = '{1, 0, 5'd6,  2'b00, 2'b01, 0, 32'h0,   32'hABCD_F00D, 32'h0,         1, 32'hFFFF_F00D};
    vecs[3]  = '{1, 0, 5'd8,  2'b00, 2'b00, 1, 32'h0,   32'h1234_5680, 32'h0,         1, 32'h0000_0080};
    vecs[4]  = '{1, 0, 5'd9,  2'b00, 2'b10, 0, 32'h0,   32'h8000_0001, 32'h0,         1, 32'h8000_0001};
    vecs[5]  = '{1, 0, 5'd10, 2'b00, 2'b11, 1, 32'h0,   32'hCAFE_BABE, 32'h0,         1, 32'hCAFE_BABE};
    vecs[6]  = '{1, 0, 5'd1,  2'b10, 2'b10, 0, 32'h104, 32'h5555_0000, 32'h3333_3333, 1, 32'h0000_0104};
    vecs[7]  = '{1, 1, 5'd1,  2'b10, 2'b10, 0, 32'h200, 32'h0,         32'h4444_4444, 0, 32'h0000_0200};
    vecs[8]  = '{1, 0, 5'd0,  2'b01, 2'b10, 0, 32'h0,   32'h0,         32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
    vecs[9]  = '{1, 0, 5'd11, 2'b11, 2'b00, 0, 32'h300, 32'hFFFF_FFFF, 32'h55AA_55AA, 1, 32'h55AA_55AA};
    vecs[10] = '{1, 0, 5'd12, 2'b01, 2'b00, 1, 32'h0,   32'h9999_9999, 32'h0000_0001, 1, 32'h0000_0001};
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reset
    idle_ctrl();
    rst        = 1'b1;
    mem_data_i = 32'h0;
    alu_i      = 32'h0;
    rs1_addr_i = 5'd0;
    rs2_addr_i = 5'd0;
    tick();
    tick();
    rst = 1'b0;
    rs1_addr_i = 5'd5;
    rs2_addr_i = 5'd31;
    #1;
    chk("reset_valid", {31'h0, wb_valid_o}, 32'h0);
    chk("reset_rd", {27'h0, wb_rd_o}, 32'h0);
    chk("reset_data", wb_data_o, 32'h0);
    chk("reset_rs1", rs1_data_o, 32'h0);
    chk("reset_rs2", rs2_data_o, 32'h0);
    alu_i = 32'h0000_0077;
    #1;
    chk("reset_sel_alu", wb_data_o, 32'h0000_0077);
    tick();

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      regWEn_i     = vecs[i].wen;
      flush_i      = vecs[i].flush;
      rd_i         = vecs[i].rd;
      wbSel_i      = vecs[i].sel;
      dataSec_i    = vecs[i].sec;
      ldUnsigned_i = vecs[i].uns;
      pc4_i        = vecs[i].pc4;
      mem_data_i   = 32'h0BAD_0BAD;
      alu_i        = 32'h0BAD_0BAD;
      tick();
      idle_ctrl();
      mem_data_i = vecs[i].mem;
      alu_i      = vecs[i].alu;
      rs1_addr_i = vecs[i].rd;
      rs2_addr_i = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_valid", i), {31'h0, wb_valid_o}, {31'h0, vecs[i].exp_valid});
      chk($sformatf("v%0d_rd", i), {27'h0, wb_rd_o}, {27'h0, vecs[i].rd});
      chk($sformatf("v%0d_data", i), wb_data_o, vecs[i].exp_data);
      chk($sformatf("v%0d_bypass1", i), rs1_data_o,
          vecs[i].exp_valid ? vecs[i].exp_data : model[vecs[i].rd]);
      chk($sformatf("v%0d_bypass2", i), rs2_data_o,
          vecs[i].exp_valid ? vecs[i].exp_data : model[vecs[i].rd]);
      if (vecs[i].exp_valid) model[vecs[i].rd] = vecs[i].exp_data;
      tick();
      #1;
      chk($sformatf("v%0d_readback", i), rs1_data_o, model[vecs[i].rd]);
    end

    // Bypass: x7 read on both ports in the cycle it is written
    rs1_addr_i = 5'd7;
    rs2_addr_i = 5'd7;
    #1;
    chk("byp_before", rs1_data_o, 32'h0);
    regWEn_i = 1'b1;
    rd_i     = 5'd7;
    wbSel_i  = 2'b01;
    tick();
    idle_ctrl();
    alu_i = 32'h1234_5678;
    #1;
    chk("byp_rs1", rs1_data_o, 32'h1234_5678);
    chk("byp_rs2", rs2_data_o, 32'h1234_5678);
    tick();
    alu_i = 32'h0;
    #1;
    chk("byp_stored", rs2_data_o, 32'h1234_5678);

    // Reset while a write to x3 is pending
    regWEn_i = 1'b1;
    rd_i     = 5'd3;
    wbSel_i  = 2'b01;
    tick();
    idle_ctrl();
    alu_i = 32'h0000_00AA;
    tick();
    rs1_addr_i = 5'd3;
    rs2_addr_i = 5'd5;
    #1;
    chk("rst_x3_aa", rs1_data_o, 32'h0000_00AA);
    regWEn_i = 1'b1;
    rd_i     = 5'd3;
    tick();
    idle_ctrl();
    alu_i = 32'h0000_00BB;
    #1;
    chk("rst_pending_valid", {31'h0, wb_valid_o}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", {31'h0, wb_valid_o}, 32'h0);
    chk("rst_x3", rs1_data_o, 32'h0);
    chk("rst_x5", rs2_data_o, 32'h0);
    tick();
    chk("rst_x3_later", rs1_data_o, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the 5-stage RV32I pipeline, directly downstream of the data-memory stage. It aligns execute-stage control with the memory stage's registered outputs (`data_o`, `alu_o`), then formats load data (byte/half sign/zero extension). It selects the writeback source and writes the integer register file. The register file's two read ports serve decode, with same-cycle write-through bypass.

## Interface

Parameters:
- `NREG`, 32: number of architectural registers; x0 is hardwired to zero.
- `XLEN`, 32: data width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `flush_i` in 1: kill the instruction currently entering the memory stage.
- `regWEn_i` in 1: instruction writes rd; presented in the same cycle as the memory stage's `addr_i`.
- `rd_i` in 5: destination register, same cycle as `regWEn_i`.
- `wbSel_i` in 2: writeback source; 00 = memory, 01 = ALU, 10 = PC+4, 11 = ALU.
- `dataSec_i` in 2: load size; 00 = byte, 01 = half, 10/11 = word.
- `ldUnsigned_i` in 1: 1 selects zero extension (LBU/LHU).
- `pc4_i` in XLEN: PC+4 of the instruction, same cycle.
- `mem_data_i` in XLEN: memory stage `data_o`, requested bytes right-aligned.
- `alu_i` in XLEN: memory stage `alu_o`.
- `rs1_addr_i`, `rs2_addr_i` in 5: decode read addresses.
- `rs1_data_o`, `rs2_data_o` out XLEN: read data, combinational.
- `wb_valid_o` out 1: a register write occurs at the next edge.
- `wb_rd_o` out 5: destination of that write.
- `wb_data_o` out XLEN: value written; also the forwarding source for execute.

## Operation

- **Alignment register.** Samples `regWEn_i`, `rd_i`, `wbSel_i`, `dataSec_i`, `ldUnsigned_i` and `pc4_i` on every edge. This matches the one-cycle latency of the memory stage.
  - The captured `valid` bit is `regWEn_i & ~flush_i`.
- **Load formatting**, applied when wbSel = 00:
  - byte: bits [7:0], extended from bit 7;
  - half: bits [15:0], extended from bit 15;
  - word: all 32 bits unchanged.
  - Extension is sign extension unless `ldUnsigned` is set, in which case it is zero extension.
  - Upper input bits are ignored for byte and half loads.
- **Source select.** `wb_data_o` is the formatted load, `alu_i`, or the captured PC+4, per the captured wbSel.
- **Write enable.** `wb_valid_o = valid & (wb_rd_o != 0)`. The register file writes `wb_data_o` to `wb_rd_o` on the edge where `wb_valid_o` is 1.
- **Reads.**
  - Address 0 always returns 0.
  - If the address equals `wb_rd_o` and `wb_valid_o` = 1, the port returns `wb_data_o` (write-through bypass).
  - Otherwise it returns the stored entry.
- **No stall input.** The memory stage has no enable, so a stall upstream must be presented to this block as `regWEn_i` = 0 bubbles.

## Timing

- **Cycle T:** control and address are presented to the memory stage and this block.
- **Edge T+1:** the alignment register captures control.
  - During T+1, `wb_data_o` and `wb_valid_o` are valid (combinational from the registers and `mem_data_i`/`alu_i`).
- **Edge T+2:** the register file is written.
- **Load-use:** a decode read in cycle T+1 sees the value through the bypass.
- **Reset, edge with `rst` = 1:**
  - the alignment register clears: valid = 0, rd = 0, wbSel = 01, dataSec = 10, ldUnsigned = 0, pc4 = 0;
  - all register-file entries clear to 0.
- **Output values after reset:**
  - `wb_valid_o` = 0 and `wb_rd_o` = 0;
  - `wb_data_o` = `alu_i`, which is 0 while the memory stage is also in reset;
  - `rs*_data_o` = 0.
- **Reset takes priority over a pending write.** An instruction already in the alignment register when `rst` rises is discarded.
- **Flush** affects only the instruction sampled on that edge. The instruction already in writeback still commits.
- **Simultaneous read and write of the same register:** the read returns the new value.
- **Both read ports on the same address:** both return identical data.
- **rd = 0:** no write and no bypass, even when valid.

## Structure

- **Shared package `rv_pkg`:**
  - `wb_sel_t` enum: `WB_MEM`, `WB_ALU`, `WB_PC4`;
  - `data_sec_t` enum: `SEC_BYTE`, `SEC_HALF`, `SEC_WORD`; the memory stage uses the same encoding;
  - constant `REG_X0` = 5'd0.
- **Sub-module `regfile`:** NREG×XLEN array, one synchronous write port, two combinational read ports with bypass and x0 hardwiring, synchronous clear on `rst`.
- Load formatting and source selection stay in `wb_stage`.

## Test plan

- **Load byte, signed:** LB with rd = 5 and `mem_data_i` = 0x00000080 one cycle after control.
  - `wb_data_o` = 0xFFFFFF80 and `wb_valid_o` = 1.
  - After the next edge, reading x5 returns 0xFFFFFF80.
- **Load half, unsigned:** LHU with `mem_data_i` = 0x0000F00D → 0x0000F00D.
  - The same case with LH → 0xFFFFF00D.
- **JAL writeback:** wbSel = PC4, `pc4_i` = 0x104, rd = 1 → x1 = 0x104.
  - The same case with `flush_i` = 1 → x1 unchanged and `wb_valid_o` = 0.
- **x0 protection:** ALU writeback rd = 0 with `alu_i` = 0xDEADBEEF.
  - `wb_valid_o` = 0 and rs1 = x0 reads 0.
- **Bypass:** write x7 = 0x12345678 while `rs1_addr_i` = `rs2_addr_i` = 7 in the same cycle → both outputs 0x12345678 before the edge.
- **Reset mid-operation:** write x3 = 0xAA; in the cycle a new write to x3 = 0xBB is pending, assert `rst`.
  - x3 = 0 and `wb_valid_o` = 0 after the edge.
